// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: control and hazard unit for a 5-stage MIPS pipeline.
// Decodes the IF/ID instruction, carries the control bundle through ID/EX, EX/MEM and MEM/WB,
// and generates load-use / MDU stalls, jump and taken-branch flushes and EX forwarding selects.
// Optional feature macro: PIPE_CTRL_MDU_EN (mult/multu/div/divu, mfhi/mflo and the MDU counter).
// Ports:
//   clk_i, reset_i (async, active-high)         clock and reset
//   id_instr_i, id_valid_i                      instruction in IF/ID and its valid flag
//   ex_br_taken_i                               branch in EX resolved taken
//   pc_write_o, ifid_write_o, ifid_flush_o      IF-side hazard controls
//   id_pc_src_o, id_ext_op_o, id_lu_op_o        ID-stage controls
//   ex_alu_src1_o, ex_alu_src2_o, ex_branch_o, ex_mdu_start_o   EX-stage controls
//   mem_read_o, mem_write_o                     MEM-stage controls
//   wb_reg_write_o, wb_mem_to_reg_o             WB-stage controls
//   ex_dst_o, mem_dst_o, wb_dst_o               destination register per stage
//   fwd_a_o, fwd_b_o                            EX operand select (00 rf, 01 MEM, 10 WB)
//   mdu_busy_o                                  MDU occupied
module pipe_ctrl_unit #(
  parameter int unsigned MDU_LAT = 32,
  parameter int unsigned RA_REG  = 31
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] id_instr_i,
  input  logic        id_valid_i,
  input  logic        ex_br_taken_i,
  output logic        pc_write_o,
  output logic        ifid_write_o,
  output logic        ifid_flush_o,
  output logic [1:0]  id_pc_src_o,
  output logic        id_ext_op_o,
  output logic        id_lu_op_o,
  output logic        ex_alu_src1_o,
  output logic        ex_alu_src2_o,
  output logic        ex_branch_o,
  output logic        ex_mdu_start_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        wb_reg_write_o,
  output logic        wb_mem_to_reg_o,
  output logic [4:0]  ex_dst_o,
  output logic [4:0]  mem_dst_o,
  output logic [4:0]  wb_dst_o,
  output logic [1:0]  fwd_a_o,
  output logic [1:0]  fwd_b_o,
  output logic        mdu_busy_o
);

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src1;
    logic       alu_src2;
    logic       branch;
    logic       mdu;
    logic       use_rs;
    logic       use_rt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
  } ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic [4:0] dst;
  } mem_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic [4:0] dst;
  } wb_t;

  typedef enum logic [1:0] {DstRt, DstRd, DstRa} dst_sel_e;

  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd;
  assign op    = id_instr_i[31:26];
  assign rs    = id_instr_i[25:21];
  assign rt    = id_instr_i[20:16];
  assign rd    = id_instr_i[15:11];
  assign funct = id_instr_i[5:0];

  ctrl_t    dec, ex_d, ex_q;
  mem_t     mem_d, mem_q;
  wb_t      wb_d, wb_q;
  dst_sel_e dst_sel;
  logic     known, id_mdu_op, load_use, mdu_stall, stall;

  // ID decode; anything not recognised (or id_valid_i low) stays an all-zero bubble.
  always_comb begin
    dec         = '0;
    known       = 1'b0;
    dst_sel     = DstRt;
    id_pc_src_o = 2'b00;
    id_ext_op_o = 1'b0;
    id_lu_op_o  = 1'b0;
    id_mdu_op   = 1'b0;
    if (id_valid_i) begin
      case (op)
        6'h00: begin
          case (funct)
            6'h00, 6'h02, 6'h03: begin  // shift by shamt
              known = 1'b1; dst_sel = DstRd;
              dec.reg_write = 1'b1; dec.alu_src1 = 1'b1; dec.use_rt = 1'b1;
            end
            6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
            6'h2A, 6'h2B: begin
              known = 1'b1; dst_sel = DstRd;
              dec.reg_write = 1'b1; dec.use_rs = 1'b1; dec.use_rt = 1'b1;
            end
            6'h08: begin  // jr
              known = 1'b1; dec.use_rs = 1'b1; id_pc_src_o = 2'b10;
            end
            6'h09: begin  // jalr
              known = 1'b1; dst_sel = DstRa;
              dec.reg_write = 1'b1; dec.use_rs = 1'b1; id_pc_src_o = 2'b10;
            end
`ifdef PIPE_CTRL_MDU_EN
            6'h10, 6'h12: begin  // mfhi/mflo
              known = 1'b1; dst_sel = DstRd; dec.reg_write = 1'b1; id_mdu_op = 1'b1;
            end
            6'h18, 6'h19, 6'h1A, 6'h1B: begin  // mult/multu/div/divu
              known = 1'b1; dec.mdu = 1'b1; dec.use_rs = 1'b1; dec.use_rt = 1'b1;
              id_mdu_op = 1'b1;
            end
`endif
            default: ;
          endcase
        end
        6'h01: begin  // bltz only
          if (rt == 5'd0) begin
            known = 1'b1; dec.branch = 1'b1; dec.use_rs = 1'b1; id_ext_op_o = 1'b1;
          end
        end
        6'h02: begin known = 1'b1; id_pc_src_o = 2'b01; end
        6'h03: begin
          known = 1'b1; dst_sel = DstRa; dec.reg_write = 1'b1; id_pc_src_o = 2'b01;
        end
        6'h04, 6'h05: begin
          known = 1'b1; dec.branch = 1'b1; dec.use_rs = 1'b1; dec.use_rt = 1'b1;
          id_ext_op_o = 1'b1;
        end
        6'h06, 6'h07: begin
          known = 1'b1; dec.branch = 1'b1; dec.use_rs = 1'b1; id_ext_op_o = 1'b1;
        end
        6'h08, 6'h09, 6'h0A, 6'h0B: begin
          known = 1'b1; dec.reg_write = 1'b1; dec.alu_src2 = 1'b1; dec.use_rs = 1'b1;
          id_ext_op_o = 1'b1;
        end
        6'h0C, 6'h0D: begin
          known = 1'b1; dec.reg_write = 1'b1; dec.alu_src2 = 1'b1; dec.use_rs = 1'b1;
        end
        6'h0F: begin
          known = 1'b1; dec.reg_write = 1'b1; dec.alu_src2 = 1'b1; id_lu_op_o = 1'b1;
        end
        6'h23: begin
          known = 1'b1; dec.reg_write = 1'b1; dec.mem_to_reg = 1'b1; dec.mem_read = 1'b1;
          dec.alu_src2 = 1'b1; dec.use_rs = 1'b1; id_ext_op_o = 1'b1;
        end
        6'h2B: begin
          known = 1'b1; dec.mem_write = 1'b1; dec.alu_src2 = 1'b1; dec.use_rs = 1'b1;
          dec.use_rt = 1'b1; id_ext_op_o = 1'b1;
        end
        default: ;
      endcase
    end
    case (dst_sel)
      DstRd:   dec.dst = rd;
      DstRa:   dec.dst = 5'(RA_REG);
      default: dec.dst = rt;
    endcase
    if (!known) dec.dst = '0;
    // Unused register numbers are zeroed so they can never produce a hazard match.
    dec.rs = dec.use_rs ? rs : '0;
    dec.rt = dec.use_rt ? rt : '0;
    if (dec.dst == '0) dec.reg_write = 1'b0;
  end

  assign load_use = ex_q.mem_read && (ex_q.dst != '0) &&
                    ((dec.use_rs && dec.rs == ex_q.dst) || (dec.use_rt && dec.rt == ex_q.dst));

`ifdef PIPE_CTRL_MDU_EN
  logic [5:0] cnt_q, cnt_d;

  // A start in EX always wins over the decrement, so back-to-back ops reload the full latency.
  always_comb begin
    cnt_d = cnt_q;
    if (ex_q.mdu)           cnt_d = 6'(MDU_LAT);
    else if (cnt_q != 6'd0) cnt_d = cnt_q - 6'd1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign mdu_busy_o     = (cnt_q != 6'd0);
  assign ex_mdu_start_o = ex_q.mdu;
  assign mdu_stall      = id_mdu_op && (mdu_busy_o || ex_q.mdu);
`else
  logic unused_mdu;
  assign unused_mdu     = id_mdu_op ^ ex_q.mdu;
  assign mdu_busy_o     = 1'b0;
  assign ex_mdu_start_o = 1'b0;
  assign mdu_stall      = 1'b0;
`endif

  logic unused_shamt;
  assign unused_shamt = ^id_instr_i[10:6];

  // A taken branch kills the ID instruction anyway, so it overrides any stall.
  assign stall        = (load_use || mdu_stall) && !ex_br_taken_i;
  assign pc_write_o   = !stall;
  assign ifid_write_o = !stall;
  assign ifid_flush_o = ex_br_taken_i || ((id_pc_src_o != 2'b00) && !stall);

  function automatic logic [1:0] fwd_sel(input logic use_r, input logic [4:0] r,
                                         input mem_t m, input wb_t w);
    if (use_r && m.reg_write && m.dst != '0 && m.dst == r) return 2'b01;
    if (use_r && w.reg_write && w.dst != '0 && w.dst == r) return 2'b10;
    return 2'b00;
  endfunction

  always_comb begin
    ex_d           = (stall || ex_br_taken_i) ? '0 : dec;
    mem_d          = '0;
    mem_d.reg_write  = ex_q.reg_write;
    mem_d.mem_to_reg = ex_q.mem_to_reg;
    mem_d.mem_read   = ex_q.mem_read;
    mem_d.mem_write  = ex_q.mem_write;
    mem_d.dst        = ex_q.dst;
    wb_d           = '0;
    wb_d.reg_write  = mem_q.reg_write;
    wb_d.mem_to_reg = mem_q.mem_to_reg;
    wb_d.dst        = mem_q.dst;
    fwd_a_o        = fwd_sel(ex_q.use_rs, ex_q.rs, mem_q, wb_q);
    fwd_b_o        = fwd_sel(ex_q.use_rt, ex_q.rt, mem_q, wb_q);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
    end
  end

  assign ex_alu_src1_o   = ex_q.alu_src1;
  assign ex_alu_src2_o   = ex_q.alu_src2;
  assign ex_branch_o     = ex_q.branch;
  assign ex_dst_o        = ex_q.dst;
  assign mem_read_o      = mem_q.mem_read;
  assign mem_write_o     = mem_q.mem_write;
  assign mem_dst_o       = mem_q.dst;
  assign wb_reg_write_o  = wb_q.reg_write;
  assign wb_mem_to_reg_o = wb_q.mem_to_reg;
  assign wb_dst_o        = wb_q.dst;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit; register writebacks are checked through a queue of
// expected destinations pushed as instructions enter EX and popped as they reach WB.
module tb_pipe_ctrl_unit;
  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [31:0] id_instr_i;
  logic        id_valid_i;
  logic        ex_br_taken_i;
  logic        pc_write_o, ifid_write_o, ifid_flush_o;
  logic [1:0]  id_pc_src_o;
  logic        id_ext_op_o, id_lu_op_o;
  logic        ex_alu_src1_o, ex_alu_src2_o, ex_branch_o, ex_mdu_start_o;
  logic        mem_read_o, mem_write_o, wb_reg_write_o, wb_mem_to_reg_o;
  logic [4:0]  ex_dst_o, mem_dst_o, wb_dst_o;
  logic [1:0]  fwd_a_o, fwd_b_o;
  logic        mdu_busy_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [4:0] exp_q[$];

  pipe_ctrl_unit #(.MDU_LAT(4), .RA_REG(31)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .id_instr_i(id_instr_i), .id_valid_i(id_valid_i),
    .ex_br_taken_i(ex_br_taken_i), .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o),
    .ifid_flush_o(ifid_flush_o), .id_pc_src_o(id_pc_src_o), .id_ext_op_o(id_ext_op_o),
    .id_lu_op_o(id_lu_op_o), .ex_alu_src1_o(ex_alu_src1_o), .ex_alu_src2_o(ex_alu_src2_o),
    .ex_branch_o(ex_branch_o), .ex_mdu_start_o(ex_mdu_start_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .wb_reg_write_o(wb_reg_write_o),
    .wb_mem_to_reg_o(wb_mem_to_reg_o), .ex_dst_o(ex_dst_o), .mem_dst_o(mem_dst_o),
    .wb_dst_o(wb_dst_o), .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o), .mdu_busy_o(mdu_busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] funct);
    return {6'h00, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] instr, input logic valid, input logic br);
    id_instr_i    = instr;
    id_valid_i    = valid;
    ex_br_taken_i = br;
    #1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    if (wb_reg_write_o === 1'b1) begin
      if (exp_q.size() == 0) chk("wb_extra", {27'd0, wb_dst_o}, 32'hffff_ffff);
      else                   chk("wb_dst", {27'd0, wb_dst_o}, {27'd0, exp_q.pop_front()});
    end
  endtask

  initial begin
    reset_i = 1'b1;
    id_instr_i = '0; id_valid_i = 1'b0; ex_br_taken_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_pc_write", pc_write_o, 1);
    chk("rst_ifid_write", ifid_write_o, 1);
    chk("rst_ifid_flush", ifid_flush_o, 0);
    chk("rst_wb_reg_write", wb_reg_write_o, 0);
    chk("rst_dsts", {ex_dst_o, mem_dst_o, wb_dst_o}, 0);
    chk("rst_fwd", {fwd_a_o, fwd_b_o}, 0);
    chk("rst_mdu", {mdu_busy_o, ex_mdu_start_o}, 0);
    reset_i = 1'b0;

    // lw $2,0($1) ; add $3,$2,$4 -> one stall cycle, then WB forwarding
    drive(itype(6'h23, 5'd1, 5'd2, 16'h0), 1, 0);
    chk("lw_no_stall", pc_write_o, 1);
    chk("lw_ext_op", id_ext_op_o, 1);
    exp_q.push_back(5'd2);
    tick();
    drive(rtype(5'd2, 5'd4, 5'd3, 6'h20), 1, 0);
    chk("lu_pc_write", pc_write_o, 0);
    chk("lu_ifid_write", ifid_write_o, 0);
    chk("lu_ex_dst", ex_dst_o, 2);
    tick();
    drive(rtype(5'd2, 5'd4, 5'd3, 6'h20), 1, 0);
    chk("lu_release", pc_write_o, 1);
    chk("lu_bubble", ex_dst_o, 0);
    chk("lu_mem_read", mem_read_o, 1);
    exp_q.push_back(5'd3);
    tick();
    drive('0, 0, 0);
    chk("lu_add_in_ex", ex_dst_o, 3);
    chk("lu_fwd_a", fwd_a_o, 2'b10);
    chk("lu_fwd_b", fwd_b_o, 2'b00);
    tick();

    // add $2,$1,$1 ; sub $5,$2,$2 -> MEM forwarding on both operands
    drive(rtype(5'd1, 5'd1, 5'd2, 6'h20), 1, 0);
    exp_q.push_back(5'd2);
    tick();
    drive(rtype(5'd2, 5'd2, 5'd5, 6'h22), 1, 0);
    chk("mf_no_stall", pc_write_o, 1);
    exp_q.push_back(5'd5);
    tick();
    drive('0, 0, 0);
    chk("mf_fwd_a", fwd_a_o, 2'b01);
    chk("mf_fwd_b", fwd_b_o, 2'b01);
    tick();
    // writer to $0 never forwards and never writes back
    drive(rtype(5'd1, 5'd1, 5'd0, 6'h20), 1, 0);
    tick();
    drive(rtype(5'd0, 5'd0, 5'd6, 6'h22), 1, 0);
    exp_q.push_back(5'd6);
    tick();
    drive('0, 0, 0);
    chk("zero_fwd", {fwd_a_o, fwd_b_o}, 0);
    tick();
    // MEM beats WB when both hold $7
    drive(rtype(5'd1, 5'd1, 5'd7, 6'h20), 1, 0);
    exp_q.push_back(5'd7);
    tick();
    drive(rtype(5'd1, 5'd1, 5'd7, 6'h21), 1, 0);
    exp_q.push_back(5'd7);
    tick();
    drive(rtype(5'd7, 5'd7, 5'd8, 6'h20), 1, 0);
    exp_q.push_back(5'd8);
    tick();
    drive('0, 0, 0);
    chk("prio_fwd", {fwd_a_o, fwd_b_o}, 4'b0101);
    tick();
    // WB-only forwarding on rs, rt=$0
    drive(rtype(5'd1, 5'd1, 5'd9, 6'h20), 1, 0);
    exp_q.push_back(5'd9);
    tick();
    drive('0, 0, 0);
    tick();
    drive(rtype(5'd9, 5'd0, 5'd10, 6'h20), 1, 0);
    exp_q.push_back(5'd10);
    tick();
    drive('0, 0, 0);
    chk("wbonly_fwd", {fwd_a_o, fwd_b_o}, 4'b1000);
    tick();

    // taken branch overrides a pending load-use stall
    drive(itype(6'h23, 5'd1, 5'd2, 16'h0), 1, 0);
    exp_q.push_back(5'd2);
    tick();
    drive(rtype(5'd2, 5'd4, 5'd3, 6'h20), 1, 1);
    chk("bt_pc_write", pc_write_o, 1);
    chk("bt_ifid_write", ifid_write_o, 1);
    chk("bt_flush", ifid_flush_o, 1);
    tick();
    drive('0, 0, 0);
    chk("bt_bubble", ex_dst_o, 0);
    chk("bt_lw_mem", mem_read_o, 1);
    tick();
    drive(itype(6'h04, 5'd1, 5'd2, 16'h4), 1, 0);
    chk("beq_ext_op", id_ext_op_o, 1);
    chk("beq_no_flush", ifid_flush_o, 0);
    tick();
    drive('0, 0, 0);
    chk("beq_ex_branch", ex_branch_o, 1);
    tick();

    // jal in ID: flush, link write reaches WB three cycles later
    drive({6'h03, 26'h40}, 1, 0);
    chk("jal_pc_src", id_pc_src_o, 2'b01);
    chk("jal_flush", ifid_flush_o, 1);
    exp_q.push_back(5'd31);
    tick();
    drive('0, 0, 0);
    tick();
    tick();
    chk("jal_wb_dst", wb_dst_o, 31);
    chk("jal_wb_write", wb_reg_write_o, 1);
    drive(rtype(5'd31, 5'd0, 5'd0, 6'h08), 1, 0);
    chk("jr_pc_src", id_pc_src_o, 2'b10);
    chk("jr_flush", ifid_flush_o, 1);
    tick();
    drive(itype(6'h0F, 5'd0, 5'd4, 16'h1234), 1, 0);
    chk("lui_lu_op", id_lu_op_o, 1);
    exp_q.push_back(5'd4);
    tick();
    drive(itype(6'h0C, 5'd1, 5'd5, 16'h00ff), 1, 0);
    chk("andi_ext_op", id_ext_op_o, 0);
    exp_q.push_back(5'd5);
    tick();
    drive('0, 0, 0);
    chk("andi_alu_src2", ex_alu_src2_o, 1);
    repeat (3) tick();

`ifdef PIPE_CTRL_MDU_EN
    // mult $6,$7 ; mflo $8 -> mflo held until the counter drains
    drive(rtype(5'd6, 5'd7, 5'd0, 6'h18), 1, 0);
    tick();
    drive(rtype(5'd0, 5'd0, 5'd8, 6'h12), 1, 0);
    chk("mdu_start", ex_mdu_start_o, 1);
    chk("mdu_idle_at_start", mdu_busy_o, 0);
    chk("mdu_stall_ex", pc_write_o, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("mdu_busy", mdu_busy_o, 1);
      chk("mdu_stall", pc_write_o, 0);
      chk("mdu_start_pulse", ex_mdu_start_o, 0);
      tick();
    end
    chk("mdu_done", mdu_busy_o, 0);
    chk("mdu_release", pc_write_o, 1);
    exp_q.push_back(5'd8);
    tick();
    drive('0, 0, 0);
    chk("mflo_ex_dst", ex_dst_o, 8);
    repeat (3) tick();
`else
    // without the MDU the mult/mflo functs are bubbles
    drive(rtype(5'd6, 5'd7, 5'd0, 6'h18), 1, 0);
    tick();
    drive(rtype(5'd0, 5'd0, 5'd8, 6'h12), 1, 0);
    chk("nomdu_start", ex_mdu_start_o, 0);
    chk("nomdu_no_stall", pc_write_o, 1);
    tick();
    drive('0, 0, 0);
    chk("nomdu_mflo_bubble", ex_dst_o, 0);
    chk("nomdu_busy", mdu_busy_o, 0);
    repeat (3) tick();
`endif

    // reset mid-stream with the pipe full of writers
    drive(rtype(5'd1, 5'd1, 5'd3, 6'h20), 1, 0);
    exp_q.push_back(5'd3);
    tick();
    drive(rtype(5'd3, 5'd3, 5'd4, 6'h20), 1, 0);
    exp_q.push_back(5'd4);
    tick();
    drive(itype(6'h23, 5'd4, 5'd11, 16'h8), 1, 0);
    exp_q.push_back(5'd11);
    tick();
    drive('0, 0, 0);
    chk("pre_rst_full", ex_dst_o, 11);
    #1;
    reset_i = 1'b1;
    #1;
    exp_q.delete();
    chk("mrst_dsts", {ex_dst_o, mem_dst_o, wb_dst_o}, 0);
    chk("mrst_wb_write", wb_reg_write_o, 0);
    chk("mrst_mem_read", mem_read_o, 0);
    chk("mrst_fwd", {fwd_a_o, fwd_b_o}, 0);
    chk("mrst_if", {pc_write_o, ifid_write_o, ifid_flush_o}, 3'b110);
    chk("mrst_mdu", mdu_busy_o, 0);
    @(negedge clk_i);
    reset_i = 1'b0;
    repeat (4) tick();
    chk("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl_unit.md
# pipe_ctrl_unit

Pipelined control and hazard unit for the 5-stage MIPS core. Decodes the instruction in ID and carries the control bundle through ID/EX, EX/MEM and MEM/WB registers. Generates load-use and multiply/divide stalls, branch/jump flushes and EX-operand forwarding selects. Replaces the purely combinational decoder.

## Interface
- `MDU_LAT`, 32: EX-stage cycles a mult/multu/div/divu occupies the MDU (1..63).
- `RA_REG`, 31: destination register for jal/jalr link.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high; clears all state.
- `id_instr` in 32: instruction currently in IF/ID.
- `id_valid` in 1: IF/ID holds a real instruction; 0 is decoded as bubble.
- `ex_br_taken` in 1: branch in EX resolved taken this cycle.
- `pc_write` out 1: PC may update.
- `ifid_write` out 1: IF/ID may load.
- `ifid_flush` out 1: IF/ID loads a bubble.
- `id_pc_src` out 2: 00 seq, 01 j/jal, 10 jr/jalr (ID-stage).
- `id_ext_op`, `id_lu_op` out 1 each: immediate sign-extend / lui select.
- `ex_alu_src1`, `ex_alu_src2`, `ex_branch`, `ex_mdu_start` out 1 each: EX controls.
- `mem_read`, `mem_write` out 1 each: MEM controls.
- `wb_reg_write`, `wb_mem_to_reg` out 1 each: WB controls.
- `ex_dst`, `mem_dst`, `wb_dst` out 5 each: destination register per stage.
- `fwd_a`, `fwd_b` out 2 each: EX operand select: 00 regfile, 01 MEM result, 10 WB result.
- `mdu_busy` out 1: MDU occupied.

## Operation
- ID decode: branch beq/bne/blez/bgtz/bltz, jumps j/jal/jr/jalr, loads/stores lw/sw, ALU R-type, shifts, I-type add/addi(u)/andi/ori/slti(u)/lui. Unknown opcodes decode as bubble (all write/mem enables 0).
- Destination: rd for R-type; `RA_REG` for jal/jalr; rt otherwise. Reg-write with destination 0 is forced to reg_write=0 at decode.
- The ID/EX register also holds rs/rt numbers, plus the uses-rs and uses-rt flags.
- Load-use stall: the EX instruction is lw with ex_dst≠0, and the ID instruction uses rs or rt equal to ex_dst. Response: pc_write=0, ifid_write=0, and ID/EX loads a bubble.
- Jump in ID (id_pc_src≠00): ifid_flush=1 next edge; the jump itself proceeds to EX.
- ex_br_taken: ifid_flush=1 and ID/EX loads a bubble; overrides any stall in the same cycle.
- Forwarding, evaluated separately for each EX operand:
  - MEM has priority: mem reg_write && mem_dst≠0 && match gives 01.
  - Otherwise WB: same condition on wb_dst gives 10.
  - Otherwise 00.
- Pipeline advance: EX/MEM and MEM/WB always advance; no stage other than IF/ID and PC is frozen.

## Timing
- All stage outputs are registered; each stage advances one stage per cycle. pc_write, ifid_write, ifid_flush, id_* and fwd_* are combinational from current state and inputs.
- Load-use stall lasts exactly 1 cycle.
- Reset values:
  - All pipeline control registers are bubble; all *_dst=0 and fwd_*=00.
  - pc_write=1, ifid_write=1, ifid_flush=0.
  - mdu_busy=0, internal MDU counter=0.
- Reset asserted mid-operation discards all in-flight control on the same cycle (asynchronous).

## Configuration
- `PIPE_CTRL_MDU_EN` defined:
  - Decodes mult/multu/div/divu (funct 18/19/1A/1B) and mfhi/mflo (funct 10/12, RegDst=1).
  - ex_mdu_start pulses 1 cycle when mult/div is in EX; the counter loads `MDU_LAT` and decrements every cycle; mdu_busy = counter≠0.
  - An ID instruction that is mult/div/mfhi/mflo while mdu_busy, or while a mult/div is in EX, stalls exactly like load-use.
  - A counter reaching 0 and a new start on the same cycle reloads `MDU_LAT`.
  - Taken-branch flush of a stalled mfhi does not affect the counter.
- `PIPE_CTRL_MDU_EN` undefined: these functs decode as bubble; mdu_busy and ex_mdu_start are tied 0.

## Test plan
- Reset asserted mid-stream, then released → all outputs at reset values.
- `lw $2,0($1)` then `add $3,$2,$4` → one cycle with pc_write=0, ifid_write=0; EX receives a bubble, then the add; add sees fwd_a=10.
- `add $2,..` then `sub $5,$2,$2` → fwd_a=fwd_b=01, no stall. Same with a dst=$0 writer → fwd 00.
- beq in EX with ex_br_taken=1 while a load-use stall is pending → ifid_flush=1, ID/EX bubble, pc_write=1.
- jal in ID → id_pc_src=01, ifid_flush=1. Three cycles later wb_dst=31 and wb_reg_write=1.
- With MDU_EN and MDU_LAT=4: mult then mflo → mdu_busy high 4 cycles; mflo held in ID until the counter hits 0. Without MDU_EN, mult writes nothing.
